// File: rtl/combination_lock_seq.sv
// Sequential combination lock: edge-detected digit entry, fail counting, timed lockout, relock.
// Optional define COMBO_PROG_CODE_EN adds ProgEn and a code register that can be rewritten while OPEN.
module combination_lock_seq #(
    parameter int DIGIT_W        = 4,
    parameter int NUM_DIGITS     = 4,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0] CODE = 16'hD7A3,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                                  Clk,
    input  logic                                  Reset,
    input  logic                                  Enter,
    input  logic [DIGIT_W-1:0]                    Digit,
    input  logic                                  Relock,
`ifdef COMBO_PROG_CODE_EN
    input  logic                                  ProgEn,
`endif
    output logic [1:0]                            State,
    output logic                                  Unlocked,
    output logic                                  LockedOut,
    output logic [$clog2(NUM_DIGITS+1)-1:0]       Progress,
    output logic [$clog2(MAX_FAILS+1)-1:0]        Fails,
    output logic                                  Error
);

    localparam int CNT_W = $clog2(NUM_DIGITS+1);
    localparam int FW    = $clog2(MAX_FAILS+1);
    localparam int TW    = $clog2(LOCKOUT_CYCLES+1);
    localparam int DEPTH = 1 << CNT_W;

    localparam logic [1:0] ST_ENTRY   = 2'b00;
    localparam logic [1:0] ST_OPEN    = 2'b01;
    localparam logic [1:0] ST_LOCKOUT = 2'b10;

    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NUM_DIGITS-1);
    localparam logic [FW-1:0]    FAIL_LAST  = FW'(MAX_FAILS-1);
    localparam logic [FW-1:0]    FAIL_MAX   = FW'(MAX_FAILS);
    localparam logic [TW-1:0]    TIMER_INIT = TW'(LOCKOUT_CYCLES);
    localparam logic [TW-1:0]    TIMER_ONE  = TW'(1);

    logic [1:0]       state_reg,    state_next;
    logic [CNT_W-1:0] progress_reg, progress_next;
    logic [FW-1:0]    fails_reg,    fails_next;
    logic [TW-1:0]    timer_reg,    timer_next;
    logic             error_reg,    error_next;
    logic             enter_q_reg;
    logic             press;

    logic [DIGIT_W*NUM_DIGITS-1:0] code_active;
    logic [DIGIT_W-1:0]            code_digit [DEPTH];

`ifdef COMBO_PROG_CODE_EN
    logic [DIGIT_W*NUM_DIGITS-1:0] code_reg,   code_next;
    logic [DIGIT_W*NUM_DIGITS-1:0] shadow_reg, shadow_next;
    assign code_active = code_reg;
`else
    assign code_active = CODE;
`endif

    // Unpack the code so digit 0 (entered first) is the most-significant field.
    // Table is padded to a power of two so Progress can index it directly.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_digit
            if (gi < NUM_DIGITS) begin : g_used
                assign code_digit[gi] = code_active[(NUM_DIGITS-1-gi)*DIGIT_W +: DIGIT_W];
            end else begin : g_pad
                assign code_digit[gi] = '0;
            end
        end
    endgenerate

    assign press = Enter & ~enter_q_reg;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg    <= ST_ENTRY;
            progress_reg <= '0;
            fails_reg    <= '0;
            timer_reg    <= '0;
            error_reg    <= 1'b0;
            enter_q_reg  <= 1'b1;   // a button held through reset is not a press
`ifdef COMBO_PROG_CODE_EN
            code_reg     <= CODE;
            shadow_reg   <= CODE;
`endif
        end else begin
            state_reg    <= state_next;
            progress_reg <= progress_next;
            fails_reg    <= fails_next;
            timer_reg    <= timer_next;
            error_reg    <= error_next;
            enter_q_reg  <= Enter;
`ifdef COMBO_PROG_CODE_EN
            code_reg     <= code_next;
            shadow_reg   <= shadow_next;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_next    = state_reg;
        progress_next = progress_reg;
        fails_next    = fails_reg;
        timer_next    = timer_reg;
        error_next    = 1'b0;
`ifdef COMBO_PROG_CODE_EN
        code_next     = code_reg;
        shadow_next   = shadow_reg;
`endif
        case (state_reg)
            ST_ENTRY: begin
                timer_next = '0;
                if (Relock) begin
                    progress_next = '0;
                end else if (press) begin
                    if (Digit == code_digit[progress_reg]) begin
                        if (progress_reg == LAST_IDX) begin
                            state_next    = ST_OPEN;
                            progress_next = '0;
                            fails_next    = '0;
                        end else begin
                            progress_next = progress_reg + 1'b1;
                        end
                    end else begin
                        error_next    = 1'b1;
                        progress_next = '0;
                        if (fails_reg >= FAIL_LAST) begin
                            state_next = ST_LOCKOUT;
                            fails_next = FAIL_MAX;
                            timer_next = TIMER_INIT;
                        end else begin
                            fails_next = fails_reg + 1'b1;
                        end
                    end
                end
            end
            ST_OPEN: begin
                timer_next = '0;
                fails_next = '0;
                if (Relock) begin
                    state_next    = ST_ENTRY;
                    progress_next = '0;
`ifdef COMBO_PROG_CODE_EN
                end else if (!ProgEn) begin
                    progress_next = '0;
                end else if (press) begin
                    // Progress doubles as the programming index while OPEN.
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (progress_reg == CNT_W'(i)) begin
                            shadow_next[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = Digit;
                        end
                    end
                    if (progress_reg == LAST_IDX) begin
                        code_next     = shadow_next;
                        progress_next = '0;
                    end else begin
                        progress_next = progress_reg + 1'b1;
                    end
`endif
                end else begin
                    progress_next = progress_reg;
                end
            end
            ST_LOCKOUT: begin
                progress_next = '0;
                if (timer_reg <= TIMER_ONE) begin
                    state_next = ST_ENTRY;
                    fails_next = '0;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            default: begin
                state_next    = ST_ENTRY;
                progress_next = '0;
                fails_next    = '0;
                timer_next    = '0;
            end
        endcase
    end

    // Output decode (all sourced from registers)
    always_comb begin
        State     = state_reg;
        Unlocked  = (state_reg == ST_OPEN);
        LockedOut = (state_reg == ST_LOCKOUT);
        Progress  = progress_reg;
        Fails     = fails_reg;
        Error     = error_reg;
    end

endmodule
